// File: rtl/cp0_tlb_regs.sv
`default_nettype none
// ============================================================================
// Module   : cp0_tlb_regs
// Purpose  : Coprocessor-0 register file (Index, EntryLo, Context, EntryHi,
//            Status, Cause, EPC, Random) and TLB write sequencer. Consumes the
//            ID-stage mtc0/mfc0/exception/eret controls and issues registered
//            one-cycle write commands to the ITLB/DTLB for tlbwi/tlbwr.
// Ports    : clk, clrn (async active-low reset)
//            wpcir                         pipeline advance (gates mtc0 and tlbw*)
//            windex..wepc, wdata           mtc0 write enables and data
//            exce, itlb_exce, dtlb_exce    exception taken / cause flags
//            eret, cause_in, sepc, v_pc..pcw  exception and return controls
//            ivpn, dvpn                    faulting virtual page numbers
//            c0rn -> c0_rdata              mfc0 read mux (combinational)
//            sta, epc                      Status and EPC registers
//            tlbwi, tlbwr -> tlb_we/widx/wvpn/wpte  registered TLB write command
// Revision : 1.0 - initial release
// ============================================================================
module cp0_tlb_regs #(
  parameter int NENT = 8,
  parameter int IDXW = 3
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            wpcir,
  input  logic            windex,
  input  logic            wentlo,
  input  logic            wcontx,
  input  logic            wenthi,
  input  logic            wsta,
  input  logic            wcau,
  input  logic            wepc,
  input  logic [31:0]     wdata,
  input  logic            exce,
  input  logic            itlb_exce,
  input  logic            dtlb_exce,
  input  logic            eret,
  input  logic [31:0]     cause_in,
  input  logic [1:0]      sepc,
  input  logic [31:0]     v_pc,
  input  logic [31:0]     pcd,
  input  logic [31:0]     pcm,
  input  logic [31:0]     pcw,
  input  logic [19:0]     ivpn,
  input  logic [19:0]     dvpn,
  input  logic [1:0]      c0rn,
  input  logic            tlbwi,
  input  logic            tlbwr,
  output logic [31:0]     c0_rdata,
  output logic [31:0]     sta,
  output logic [31:0]     epc,
  output logic            tlb_we,
  output logic [IDXW-1:0] tlb_widx,
  output logic [19:0]     tlb_wvpn,
  output logic [23:0]     tlb_wpte
);

  localparam logic [IDXW-1:0] c_rand_top = IDXW'(NENT - 1);

  logic [31:0]     r_sta;
  logic [31:0]     r_cause;
  logic [31:0]     r_epc;
  logic [31:0]     r_context;
  logic [IDXW-1:0] r_index;
  logic [31:0]     r_entrylo;
  logic [31:0]     r_entryhi;
  logic [IDXW-1:0] r_random;
  logic            r_tlb_we;
  logic [IDXW-1:0] r_tlb_widx;
  logic [19:0]     r_tlb_wvpn;
  logic [23:0]     r_tlb_wpte;

  logic [19:0]     w_exc_vpn;
  logic [31:0]     w_epc_src;
  logic            w_tlb_go;
  logic            w_unused;

  // The ITLB fault wins when both TLBs fault in the same cycle.
  assign w_exc_vpn = itlb_exce ? ivpn : dvpn;

  always_comb begin
    w_epc_src = v_pc;
    case (sepc)
      2'b00:   w_epc_src = v_pc;
      2'b01:   w_epc_src = pcd;
      2'b10:   w_epc_src = pcm;
      default: w_epc_src = pcw;
    endcase
  end

  // A TLB write in the same cycle as an exception must not reach the TLB.
  assign w_tlb_go = (tlbwi | tlbwr) & wpcir & ~exce;

  // Status: exception pushes an 8-bit frame of zeros (masks TLB exceptions),
  // eret pops it back.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_sta <= 32'h0;
    end else if (exce) begin
      r_sta <= {r_sta[23:0], 8'h00};
    end else if (eret) begin
      r_sta <= {8'h00, r_sta[31:8]};
    end else if (wsta && wpcir) begin
      r_sta <= wdata;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_cause <= 32'h0;
      r_epc   <= 32'h0;
    end else begin
      if (exce) begin
        r_cause <= cause_in;
      end else if (wcau && wpcir) begin
        r_cause <= wdata;
      end
      if (exce) begin
        r_epc <= w_epc_src;
      end else if (wepc && wpcir) begin
        r_epc <= wdata;
      end
    end
  end

  // Context: software owns only the PTE base [31:22]; the bad VPN field is
  // hardware-written on exceptions and bits [1:0] stay zero.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_context <= 32'h0;
      r_entryhi <= 32'h0;
    end else begin
      if (exce) begin
        r_context[21:2] <= w_exc_vpn;
      end else if (wcontx && wpcir) begin
        r_context[31:22] <= wdata[31:22];
      end
      if (exce) begin
        r_entryhi[31:12] <= w_exc_vpn;
      end else if (wenthi && wpcir) begin
        r_entryhi <= wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_index   <= '0;
      r_entrylo <= 32'h0;
    end else begin
      if (windex && wpcir) begin
        r_index <= wdata[IDXW-1:0];
      end
      if (wentlo && wpcir) begin
        r_entrylo <= wdata;
      end
    end
  end

  // NENT is a power of two, so the natural binary wrap 0 -> all-ones is
  // exactly 0 -> NENT-1.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_random <= c_rand_top;
    end else begin
      r_random <= r_random - IDXW'(1);
    end
  end

  // TLB write command: strobe is a single-cycle pulse; data outputs hold
  // their last value between writes.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_tlb_we   <= 1'b0;
      r_tlb_widx <= '0;
      r_tlb_wvpn <= 20'h0;
      r_tlb_wpte <= 24'h0;
    end else begin
      r_tlb_we <= w_tlb_go;
      if (w_tlb_go) begin
        r_tlb_widx <= tlbwi ? r_index : r_random;
        r_tlb_wvpn <= r_entryhi[31:12];
        r_tlb_wpte <= r_entrylo[23:0];
      end
    end
  end

  always_comb begin
    c0_rdata = r_context;
    case (c0rn)
      2'b00:   c0_rdata = r_context;
      2'b01:   c0_rdata = r_sta;
      2'b10:   c0_rdata = r_cause;
      default: c0_rdata = r_epc;
    endcase
  end

  assign sta      = r_sta;
  assign epc      = r_epc;
  assign tlb_we   = r_tlb_we;
  assign tlb_widx = r_tlb_widx;
  assign tlb_wvpn = r_tlb_wvpn;
  assign tlb_wpte = r_tlb_wpte;

  // Fields held for software/hardware symmetry but never read out here.
  assign w_unused = ^{dtlb_exce, r_entryhi[11:0], r_entrylo[31:24]};

endmodule
`default_nettype wire

// File: tb/tb_cp0_tlb_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_cp0_tlb_regs
// Purpose  : Self-checking bench for cp0_tlb_regs. Directed scenarios followed
//            by randomized traffic, all checked against a behavioural model
//            of the CP0 registers and the TLB write command.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cp0_tlb_regs;

  localparam int NENT = 8;
  localparam int IDXW = 3;

  logic            clk;
  logic            clrn;
  logic            wpcir;
  logic            windex, wentlo, wcontx, wenthi, wsta, wcau, wepc;
  logic [31:0]     wdata;
  logic            exce, itlb_exce, dtlb_exce, eret;
  logic [31:0]     cause_in;
  logic [1:0]      sepc;
  logic [31:0]     v_pc, pcd, pcm, pcw;
  logic [19:0]     ivpn, dvpn;
  logic [1:0]      c0rn;
  logic            tlbwi, tlbwr;
  logic [31:0]     c0_rdata, sta, epc;
  logic            tlb_we;
  logic [IDXW-1:0] tlb_widx;
  logic [19:0]     tlb_wvpn;
  logic [23:0]     tlb_wpte;

  cp0_tlb_regs #(.NENT(NENT), .IDXW(IDXW)) dut (
    .clk(clk), .clrn(clrn), .wpcir(wpcir),
    .windex(windex), .wentlo(wentlo), .wcontx(wcontx), .wenthi(wenthi),
    .wsta(wsta), .wcau(wcau), .wepc(wepc), .wdata(wdata),
    .exce(exce), .itlb_exce(itlb_exce), .dtlb_exce(dtlb_exce), .eret(eret),
    .cause_in(cause_in), .sepc(sepc),
    .v_pc(v_pc), .pcd(pcd), .pcm(pcm), .pcw(pcw),
    .ivpn(ivpn), .dvpn(dvpn), .c0rn(c0rn),
    .tlbwi(tlbwi), .tlbwr(tlbwr),
    .c0_rdata(c0_rdata), .sta(sta), .epc(epc),
    .tlb_we(tlb_we), .tlb_widx(tlb_widx), .tlb_wvpn(tlb_wvpn), .tlb_wpte(tlb_wpte)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] m_sta, m_cause, m_epc, m_ctx, m_elo, m_ehi;
  int          m_idx;
  int          m_cyc;   // clock edges since reset release
  logic        m_we;
  int          m_widx;
  logic [19:0] m_wvpn;
  logic [23:0] m_wpte;

  // Random counts down from NENT-1 one step per edge, modulo NENT.
  function automatic int model_random();
    return (NENT - 1) - (m_cyc % NENT);
  endfunction

  task automatic model_reset();
    m_sta = 0; m_cause = 0; m_epc = 0; m_ctx = 0; m_elo = 0; m_ehi = 0;
    m_idx = 0; m_cyc = 0; m_we = 0; m_widx = 0; m_wvpn = 0; m_wpte = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] sel);
    case (sel)
      2'd0:    return m_ctx;
      2'd1:    return m_sta;
      2'd2:    return m_cause;
      default: return m_epc;
    endcase
  endfunction

  task automatic check_all();
    chk("sta", sta, m_sta);
    chk("epc", epc, m_epc);
    chk("c0_rdata", c0_rdata, model_read(c0rn));
    chk("tlb_we", {31'b0, tlb_we}, {31'b0, m_we});
    chk("tlb_widx", 32'(tlb_widx), 32'(m_widx));
    chk("tlb_wvpn", {12'b0, tlb_wvpn}, {12'b0, m_wvpn});
    chk("tlb_wpte", {8'b0, tlb_wpte}, {8'b0, m_wpte});
  endtask

  task automatic clear_in();
    wpcir = 1; windex = 0; wentlo = 0; wcontx = 0; wenthi = 0;
    wsta = 0; wcau = 0; wepc = 0; wdata = 0;
    exce = 0; itlb_exce = 0; dtlb_exce = 0; eret = 0; cause_in = 0; sepc = 0;
    v_pc = 32'h100; pcd = 32'h104; pcm = 32'h108; pcw = 32'h10C;
    ivpn = 0; dvpn = 0; c0rn = 0; tlbwi = 0; tlbwr = 0;
  endtask

  // One clock: predict from the current inputs, advance, compare.
  task automatic step();
    logic [19:0] vpn;
    logic        acc, go;
    logic [31:0] n_sta, n_cause, n_epc, n_ctx, n_ehi;
    vpn   = itlb_exce ? ivpn : dvpn;
    acc   = wpcir;
    n_sta = m_sta; n_cause = m_cause; n_epc = m_epc; n_ctx = m_ctx; n_ehi = m_ehi;
    if (exce)                n_sta = m_sta << 8;
    else if (eret)           n_sta = m_sta >> 8;
    else if (wsta && acc)    n_sta = wdata;
    if (exce)                n_cause = cause_in;
    else if (wcau && acc)    n_cause = wdata;
    if (exce)                n_epc = (sepc == 0) ? v_pc : (sepc == 1) ? pcd : (sepc == 2) ? pcm : pcw;
    else if (wepc && acc)    n_epc = wdata;
    if (exce)                n_ctx = (m_ctx & 32'hFFC0_0000) | (32'(vpn) << 2);
    else if (wcontx && acc)  n_ctx = (wdata & 32'hFFC0_0000) | (m_ctx & 32'h003F_FFFF);
    if (exce)                n_ehi = (32'(vpn) << 12) | (m_ehi & 32'h0000_0FFF);
    else if (wenthi && acc)  n_ehi = wdata;
    go = (tlbwi || tlbwr) && acc && !exce;
    m_we = go;
    if (go) begin
      m_widx = tlbwi ? m_idx : model_random();
      m_wvpn = m_ehi[31:12];
      m_wpte = m_elo[23:0];
    end
    if (windex && acc) m_idx = int'(wdata % NENT);
    if (wentlo && acc) m_elo = wdata;
    m_sta = n_sta; m_cause = n_cause; m_epc = n_epc; m_ctx = n_ctx; m_ehi = n_ehi;
    m_cyc++;
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    int pulses;
    clear_in();
    model_reset();
    clrn = 0;

    // ---- Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all();
    for (int s = 0; s < 4; s++) begin
      c0rn = 2'(s);
      #1;
      chk("reset_rdata", c0_rdata, 32'h0);
    end
    c0rn = 0;
    clrn = 1;

    // ---- Back-to-back tlbwr walks the Random register 7,6,...,0,7
    tlbwr = 1;
    for (int k = 0; k < 9; k++) begin
      step();
      chk("random_seq", 32'(tlb_widx), 32'((NENT - 1 - k) & (NENT - 1)));
    end
    tlbwr = 0;
    step();

    // ---- Exception push / eret pop
    wsta = 1; wdata = 32'h0000_0030;
    step();
    clear_in();
    exce = 1; itlb_exce = 1; dtlb_exce = 1; ivpn = 20'h12345; dvpn = 20'hABCDE;
    sepc = 2'b01; pcd = 32'h0000_0404; wsta = 1; wcau = 1; wepc = 1;
    cause_in = 32'h0000_0020; c0rn = 2'b00;
    step();
    chk("exc_sta", sta, 32'h0000_3000);
    chk("exc_epc", epc, 32'h0000_0404);
    chk("exc_context", c0_rdata, 32'h0004_8D14);
    clear_in();
    eret = 1; c0rn = 2'b01;
    step();
    chk("eret_sta", sta, 32'h0000_0030);
    clear_in();
    tlbwi = 1;
    step();
    chk("exc_entryhi", {12'b0, tlb_wvpn}, 32'h0001_2345);
    clear_in();

    // ---- mtc0 then tlbwi
    wentlo = 1; wdata = 32'h0000_ABCD; step();
    clear_in(); wenthi = 1; wdata = 32'h0040_0000; step();
    clear_in(); windex = 1; wdata = 32'd5; step();
    clear_in(); tlbwi = 1; step();
    chk("tlbwi_we", {31'b0, tlb_we}, 32'd1);
    chk("tlbwi_idx", 32'(tlb_widx), 32'd5);
    chk("tlbwi_vpn", {12'b0, tlb_wvpn}, 32'h0000_0400);
    chk("tlbwi_pte", {8'b0, tlb_wpte}, 32'h0000_ABCD);
    clear_in(); step();
    chk("tlbwi_we_drop", {31'b0, tlb_we}, 32'd0);

    // ---- Stalled tlbwi produces exactly one strobe
    pulses = 0;
    tlbwi = 1; wpcir = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      pulses += int'(tlb_we);
    end
    wpcir = 1; step();
    pulses += int'(tlb_we);
    chk("stall_we_on_accept", {31'b0, tlb_we}, 32'd1);
    clear_in();
    for (int k = 0; k < 2; k++) begin
      step();
      pulses += int'(tlb_we);
    end
    chk("stall_pulses", 32'(pulses), 32'd1);

    // ---- Exception beats mtc0 Cause; suppresses tlbwr
    wcau = 1; wdata = 32'hFFFF_FFFF; exce = 1; dtlb_exce = 1; dvpn = 20'h00777;
    cause_in = 32'h0000_0014; tlbwr = 1; c0rn = 2'b10;
    step();
    chk("exc_cause", c0_rdata, 32'h0000_0014);
    chk("exc_tlb_suppr", {31'b0, tlb_we}, 32'd0);
    clear_in();

    // ---- Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      wpcir     = ($urandom_range(3) != 0);
      windex    = ($urandom_range(5) == 0);
      wentlo    = ($urandom_range(5) == 0);
      wcontx    = ($urandom_range(5) == 0);
      wenthi    = ($urandom_range(5) == 0);
      wsta      = ($urandom_range(5) == 0);
      wcau      = ($urandom_range(5) == 0);
      wepc      = ($urandom_range(5) == 0);
      wdata     = $urandom;
      exce      = ($urandom_range(7) == 0);
      itlb_exce = $urandom_range(1) == 1;
      dtlb_exce = !itlb_exce;
      eret      = ($urandom_range(7) == 0);
      cause_in  = $urandom;
      sepc      = 2'($urandom_range(3));
      v_pc = $urandom; pcd = $urandom; pcm = $urandom; pcw = $urandom;
      ivpn = 20'($urandom); dvpn = 20'($urandom);
      c0rn  = 2'($urandom_range(3));
      tlbwi = ($urandom_range(3) == 0);
      tlbwr = ($urandom_range(3) == 0);
      step();
    end
    clear_in();

    // ---- Asynchronous reset aborts a pending TLB write
    tlbwr = 1; step();
    chk("pre_reset_we", {31'b0, tlb_we}, 32'd1);
    clear_in();
    #2 clrn = 0;
    #1;
    chk("async_we", {31'b0, tlb_we}, 32'd0);
    chk("async_widx", 32'(tlb_widx), 32'd0);
    chk("async_wvpn", {12'b0, tlb_wvpn}, 32'd0);
    chk("async_sta", sta, 32'd0);
    model_reset();
    @(posedge clk);
    #1 clrn = 1;
    tlbwr = 1; step();
    chk("random_after_reset", 32'(tlb_widx), 32'(NENT - 1));
    clear_in(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cp0_tlb_regs.md
# cp0_tlb_regs

Coprocessor-0 register file and TLB write sequencer for the pipelined CPU with TLB-based address translation. It holds the Index, EntryLo, Context, EntryHi, Status, Cause and EPC registers, plus a free-running Random register. It consumes the write enables, read selects, exception and eret controls that the pipeline control unit decodes in the ID stage. It issues registered single-cycle write commands to the ITLB/DTLB for `tlbwi`/`tlbwr`.

## Interface
- NENT, 8, number of TLB entries (power of two, 2..32)
- IDXW, 3, index width, log2(NENT)

- clk  in  1  clock, all state updates on rising edge
- clrn  in  1  asynchronous active-low reset
- wpcir  in  1  pipeline advance; gates every write except exception/eret effects
- windex, wentlo, wcontx, wenthi, wsta, wcau, wepc  in  1 each  mtc0 register write enables (wsta/wcau/wepc also asserted by exce)
- wdata  in  32  GPR[rt] value for mtc0
- exce  in  1  masked TLB exception taken this cycle
- itlb_exce, dtlb_exce  in  1  individual exception causes
- eret  in  1  eret in ID stage
- cause_in  in  32  exception cause word from control unit
- sepc  in  2  EPC source select: 00 v_pc, 01 pcd, 10 pcm, 11 pcw
- v_pc, pcd, pcm, pcw  in  32  candidate EPC values
- ivpn, dvpn  in  20  faulting virtual page numbers (instruction, data)
- c0rn  in  2  mfc0 read select: 00 Context, 01 Status, 10 Cause, 11 EPC
- tlbwi, tlbwr  in  1  TLB write by index / by random
- c0_rdata  out  32  selected register, combinational
- sta  out  32  Status register (IM bits feed exception masking)
- epc  out  32  EPC register (eret target)
- tlb_we  out  1  registered TLB write strobe
- tlb_widx  out  IDXW  TLB entry to write
- tlb_wvpn  out  20  VPN to write (EntryHi[31:12])
- tlb_wpte  out  24  PTE to write (EntryLo[23:0])

## Operation
- Write priority per register: exception effect > eret effect > mtc0 (mtc0 requires enable & wpcir).
- Status: on exce, sta <= {sta[23:0], 8'h00} (push; disables TLB exceptions). Else on eret, sta <= {8'h00, sta[31:8]} (pop). Else on wsta&wpcir, sta <= wdata.
- Cause: on exce, cause <= cause_in; else on wcau&wpcir, cause <= wdata.
- EPC: on exce, epc <= sepc-selected PC; else on wepc&wpcir, epc <= wdata.
- Context: mtc0 writes context[31:22] <= wdata[31:22] only; bits [21:0] are read-only. On exce, context[21:2] <= itlb_exce ? ivpn : dvpn; [1:0] always 0.
- EntryHi: mtc0 writes full word. On exce, entryhi[31:12] <= the same VPN as Context (ITLB takes priority); [11:0] unchanged.
- Index: windex&wpcir, index <= wdata[IDXW-1:0]. EntryLo: wentlo&wpcir, entrylo <= wdata.
- Random: decrements every cycle; wraps from 0 to NENT-1; not writable.
- TLB write: when (tlbwi|tlbwr)&wpcir, the next edge loads tlb_we=1 and tlb_widx=(tlbwi ? index : random, value before the edge). It also loads tlb_wvpn=entryhi[31:12] and tlb_wpte=entrylo[23:0]. In any other cycle tlb_we is 0; the data outputs hold their values.
- If exce and tlbwi/tlbwr are asserted together, the TLB write is suppressed.
- c0_rdata is a pure mux of current register values (no bypass of same-cycle writes).

## Timing
- Reset (clrn=0, asynchronous): sta, cause, epc, context, index, entrylo, entryhi = 0; random = NENT-1; tlb_we = 0, tlb_widx = 0, tlb_wvpn = 0, tlb_wpte = 0.
- Reset mid-operation aborts any pending TLB write immediately.
- All register writes take effect at the rising edge ending the ID cycle; visible on c0_rdata/sta/epc the following cycle.
- TLB write latency: one cycle. tlb_we is high exactly one cycle per accepted tlbwi/tlbwr.
- Back-to-back tlbwr instructions produce consecutive strobes with different random indices.
- A stalled tlbwi/tlbwr (wpcir=0) issues no strobe; it issues exactly one when accepted.
- mtc0 EntryHi followed by tlbwi next cycle uses the new EntryHi.

## Test plan
- Reset, then 9 idle cycles -> random sequence 7,6,5,4,3,2,1,0,7; all other outputs 0.
- mtc0 Status=32'h0000_0030, then exce with itlb_exce=1, ivpn=20'h12345, sepc=01, pcd=32'h0000_0404 -> sta=32'h0000_3000, epc=32'h0000_0404, context=32'h0048_D14 shifted (context[21:2]=20'h12345), entryhi[31:12]=20'h12345. Then eret -> sta=32'h0000_0030.
- mtc0 EntryLo=32'h0000_ABCD, EntryHi=32'h0040_0000, Index=5, then tlbwi -> next cycle tlb_we=1, tlb_widx=5, tlb_wvpn=20'h00400, tlb_wpte=24'h00ABCD; following cycle tlb_we=0.
- tlbwi held with wpcir=0 for 3 cycles, then wpcir=1 -> exactly one tlb_we pulse, one cycle after acceptance.
- exce and mtc0 Cause (wdata=32'hFFFF_FFFF) in the same cycle with cause_in=32'h14 -> cause=32'h14. Same cycle tlbwr -> no tlb_we.
- Drop clrn while tlb_we=1 -> tlb_we=0 and random=NENT-1 immediately, without waiting for a clock.
